// File: rtl/vga_screen_scan_if.sv
// Interface between the scan-out stage, the frame-buffer read port and the VGA pins.
interface vga_screen_scan_if;
    logic        en;
    logic [14:0] screen_addr;
    logic [11:0] screen_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_start;

    modport master (
        input  en, screen_data,
        output screen_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
    );

    modport slave (
        output en, screen_data,
        input  screen_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
    );
endinterface

// File: rtl/vga_screen_scan.sv
// VGA scan-out: pixel-rate timing, frame-buffer address generation with 4x4
// pixel replication, and a two-tick pipeline keeping syncs aligned with RGB.
module vga_screen_scan #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int FB_WIDTH    = 160,
    parameter int SCALE_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    vga_screen_scan_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [14:0]   FB_W     = 15'(FB_WIDTH);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tick;
    logic          de;
    logic          hs_n;
    logic          vs_n;
    logic          at_origin;
    logic [14:0]   fb_row;
    logic [14:0]   fb_col;
    logic [14:0]   addr_next;

    logic          de1;
    logic          hs1;
    logic          vs1;
    logic          first1;
    logic [14:0]   addr_q;
    logic [11:0]   rgb_q;
    logic          hs_q;
    logic          vs_q;
    logic          fs_q;

    // Pixel tick and decode of the current (pre-increment) counter position.
    always_comb begin
        tick      = (div_cnt == DIV_LAST);
        de        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n      = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        vs_n      = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        fb_row    = 15'(v_cnt >> SCALE_SHIFT);
        fb_col    = 15'(h_cnt >> SCALE_SHIFT);
    end

    // Row base: the 160-wide buffer uses a 128+32 shift-add instead of a multiplier.
    generate
        if (FB_WIDTH == 160) begin : g_shift_add
            assign addr_next = (fb_row << 7) + (fb_row << 5) + fb_col;
        end else begin : g_mult
            assign addr_next = fb_row * FB_W + fb_col;
        end
    endgenerate

    // Divider, scan counters and the two pipeline stages; en low acts like reset.
    always_ff @(posedge clk) begin
        if (!rstn || !bus.en) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            de1     <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            first1  <= 1'b0;
            addr_q  <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
                de1    <= de;
                hs1    <= hs_n;
                vs1    <= vs_n;
                first1 <= at_origin;
                if (de) begin
                    addr_q <= addr_next;
                end
                rgb_q <= de1 ? bus.screen_data : 12'h000;
                hs_q  <= hs1;
                vs_q  <= vs1;
                fs_q  <= first1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign bus.screen_addr = addr_q;
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.frame_start = fs_q;
endmodule
